fetch_unit: RTL and testbench

//  Instruction-fetch front end of the 16-bit processor: program counter, PC incrementer,
//  1024x16 instruction memory and instruction register with field decode.

---
 rtl/fetch_unit.sv | 69 ++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit : PC, +1 incrementer, run-time loadable IM and decoded IR     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch,
  input  logic              stall,
  input  logic [ADDR_W-1:0] br_address,
  input  logic              en_write,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] instr_address,
  output logic [DATA_W-1:0] data_out,
  output logic [5:0]        op_code,
  output logic              reg_s,
  output logic              acc_s,
  output logic [7:0]        val
);

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mem [DEPTH];

  // Carry out of the incrementer is dropped so the PC wraps 1023 -> 0.
  assign pc_inc = instr_address + ADDR_W'(1);

  always_comb begin
    pc_next = pc_inc;
    if (stall) begin
      pc_next = instr_address;
    end else if (branch) begin
      pc_next = br_address;
    end
  end

  // The IR samples the pre-edge read data, so it is never gated by stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_address <= '0;
      ir            <= '0;
    end else begin
      instr_address <= pc_next;
      ir            <= data_out;
    end
  end

  // Program storage survives reset so a restart replays the loaded code.
  always_ff @(posedge clk) begin
    if (en_write) begin
      mem[instr_address] <= data_in;
    end
  end

  assign data_out = mem[instr_address];

  assign op_code = ir[15:10];
  assign reg_s   = ir[9];
  assign acc_s   = ir[8];
  assign val     = ir[7:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Testbench for fetch_unit: scoreboard of expected PC/IR per clock plus
// scenario-specific checks against hand-decoded instruction constants.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        branch;
  logic        stall;
  logic [9:0]  br_address;
  logic        en_write;
  logic [15:0] data_in;
  logic [9:0]  instr_address;
  logic [15:0] data_out;
  logic [5:0]  op_code;
  logic        reg_s;
  logic        acc_s;
  logic [7:0]  val;

  fetch_unit #(.ADDR_W(10), .DATA_W(16), .DEPTH(1024)) dut (
    .clk           (clk),
    .reset         (reset),
    .branch        (branch),
    .stall         (stall),
    .br_address    (br_address),
    .en_write      (en_write),
    .data_in       (data_in),
    .instr_address (instr_address),
    .data_out      (data_out),
    .op_code       (op_code),
    .reg_s         (reg_s),
    .acc_s         (acc_s),
    .val           (val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  pc;
    logic [15:0] ir;
    bit          ir_known;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;

  logic [15:0] m_mem [1024];
  bit          m_ok  [1024];
  logic [9:0]  m_pc;
  logic [15:0] m_ir;
  bit          m_ir_ok;

  logic [15:0] prog [4] = '{16'h040D, 16'h280C, 16'h2C14, 16'h080D};

  task automatic model_reset();
    m_pc    = '0;
    m_ir    = '0;
    m_ir_ok = 1'b1;
    sbq.delete();
  endtask

  // One clock: drive inputs, predict the post-edge state, then pop and compare.
  task automatic cycle(input logic b, input logic s, input logic [9:0] ba,
                       input logic we, input logic [15:0] din);
    exp_t e;
    exp_t got;
    branch = b; stall = s; br_address = ba; en_write = we; data_in = din;
    #1;
    if (m_ok[m_pc]) begin
      checks++;
      if (data_out !== m_mem[m_pc]) begin
        errors++;
        $display("FAIL data_out pc=%0d: got %h expected %h", m_pc, data_out, m_mem[m_pc]);
      end
    end
    m_ir    = m_mem[m_pc];
    m_ir_ok = m_ok[m_pc];
    if (we) begin
      m_mem[m_pc] = din;
      m_ok[m_pc]  = 1'b1;
    end
    if (!s) m_pc = b ? ba : m_pc + 10'd1;
    e.pc = m_pc; e.ir = m_ir; e.ir_known = m_ir_ok;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    checks++;
    if (instr_address !== got.pc) begin
      errors++;
      $display("FAIL sb_pc: got %0d expected %0d", instr_address, got.pc);
    end
    if (got.ir_known) begin
      checks++;
      if ({op_code, reg_s, acc_s, val} !== got.ir) begin
        errors++;
        $display("FAIL sb_ir at pc=%0d: got %h expected %h", got.pc,
                 {op_code, reg_s, acc_s, val}, got.ir);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; branch = 0; stall = 0; br_address = '0; en_write = 0; data_in = '0;
    model_reset();
    #25;
    checks++;
    if (instr_address !== 10'd0 || {op_code, reg_s, acc_s, val} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: got pc=%0d ir=%h expected pc=0 ir=0000",
               instr_address, {op_code, reg_s, acc_s, val});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_program_load();
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 10'd0, 1'b1, prog[i % 4]);
    checks++;
    if (instr_address !== 10'd12) begin
      errors++;
      $display("FAIL load_pc_end: got %0d expected 12", instr_address);
    end
  endtask

  task automatic test_replay();
    @(negedge clk);
    reset = 1'b0; en_write = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
    checks++;
    if (data_out !== 16'h040D) begin
      errors++;
      $display("FAIL replay_dout0: got %h expected 040D", data_out);
    end
    cycle(1'b0, 1'b0, 10'd0, 1'b0, 16'h0);
    checks++;
    if (op_code !== 6'h01 || reg_s !== 1'b0 || acc_s !== 1'b0 || val !== 8'h0D) begin
      errors++;
      $display("FAIL decode_040D: got op=%h rs=%b as=%b val=%h expected op=01 rs=0 as=0 val=0d",
               op_code, reg_s, acc_s, val);
    end
    checks++;
    if (data_out !== 16'h280C) begin
      errors++;
      $display("FAIL replay_dout1: got %h expected 280C", data_out);
    end
    cycle(1'b0, 1'b0, 10'd0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 10'd0, 1'b0, 16'h0);
    checks++;
    if (op_code !== 6'h0B || reg_s !== 1'b0 || acc_s !== 1'b0 || val !== 8'h14) begin
      errors++;
      $display("FAIL decode_2C14: got op=%h rs=%b as=%b val=%h expected op=0b rs=0 as=0 val=14",
               op_code, reg_s, acc_s, val);
    end
    cycle(1'b0, 1'b0, 10'd0, 1'b0, 16'h0);
  endtask

  task automatic test_stall();
    cycle(1'b0, 1'b0, 10'd0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 10'd0, 1'b0, 16'h0);
    checks++;
    if (instr_address !== 10'd5 || op_code !== 6'h0A || val !== 8'h0C) begin
      errors++;
      $display("FAIL stall_hold: got pc=%0d op=%h val=%h expected pc=5 op=0a val=0c",
               instr_address, op_code, val);
    end
  endtask

  task automatic test_branch();
    cycle(1'b1, 1'b0, 10'd2, 1'b0, 16'h0);
    checks++;
    if (instr_address !== 10'd2) begin
      errors++;
      $display("FAIL branch_pc: got %0d expected 2", instr_address);
    end
    cycle(1'b0, 1'b0, 10'd0, 1'b0, 16'h0);
    checks++;
    if (op_code !== 6'h0B || val !== 8'h14) begin
      errors++;
      $display("FAIL branch_ir: got op=%h val=%h expected op=0b val=14", op_code, val);
    end
    cycle(1'b1, 1'b1, 10'd9, 1'b0, 16'h0);
    checks++;
    if (instr_address !== 10'd3) begin
      errors++;
      $display("FAIL branch_stall_prio: got %0d expected 3", instr_address);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 1'b0, 10'd1023, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 10'd0, 1'b0, 16'h0);
    checks++;
    if (instr_address !== 10'd0) begin
      errors++;
      $display("FAIL wrap_zero: got %0d expected 0", instr_address);
    end
    cycle(1'b0, 1'b0, 10'd0, 1'b0, 16'h0);
    checks++;
    if (instr_address !== 10'd1 || op_code !== 6'h01) begin
      errors++;
      $display("FAIL wrap_one: got pc=%0d op=%h expected pc=1 op=01", instr_address, op_code);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 10'd6, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 10'd0, 1'b0, 16'h0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (instr_address !== 10'd0 || op_code !== 6'h00 || reg_s !== 1'b0 ||
        acc_s !== 1'b0 || val !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got pc=%0d ir=%h expected pc=0 ir=0000",
               instr_address, {op_code, reg_s, acc_s, val});
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 10'd0, 1'b0, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      m_mem[i] = '0;
      m_ok[i]  = 1'b0;
    end
    test_reset();
    test_program_load();
    test_replay();
    test_stall();
    test_branch();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
